// File: rtl/cordic_result_packer_if.sv
// Bus bundle between a CORDIC result source/sink and the result packer.
// The master drives bytes, clear and pop requests; the slave returns the FIFO view.
interface cordic_result_packer_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic          cap_en;
  logic          res_valid;
  logic [7:0]    res_in;
  logic          clr;
  logic          rd_en;
  logic [31:0]   rd_data;
  logic          rd_valid;
  logic [LW-1:0] level;
  logic [1:0]    byte_idx;
  logic          overflow;

  modport master (
    output cap_en, res_valid, res_in, clr, rd_en,
    input  rd_data, rd_valid, level, byte_idx, overflow
  );

  modport slave (
    input  cap_en, res_valid, res_in, clr, rd_en,
    output rd_data, rd_valid, level, byte_idx, overflow
  );
endinterface

// File: rtl/cordic_result_packer.sv
// Packs CORDIC result bytes little-endian into 32-bit words and queues them
// in a first-word-fall-through FIFO with a sticky overflow flag.
module cordic_result_packer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_n,
  cordic_result_packer_if.slave  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    LANE0 = 2'd0,
    LANE1 = 2'd1,
    LANE2 = 2'd2,
    LANE3 = 2'd3
  } lane_t;

  lane_t         r_lane;
  lane_t         w_lane_nxt;
  logic [23:0]   r_asm;
  logic [31:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic          r_ovf;

  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_wr;
  logic          w_drop;
  logic [31:0]   w_word;

  assign w_accept = bus.cap_en & bus.res_valid;
  assign w_full   = (r_level == LW'(FIFO_DEPTH));
  assign w_pop    = bus.rd_en & (r_level != '0);
  // A full FIFO still takes the new word when the head leaves on the same edge.
  assign w_wr     = w_push & (~w_full | w_pop);
  assign w_drop   = w_push & w_full & ~w_pop;
  assign w_word   = {bus.res_in, r_asm};

  always_comb begin
    w_lane_nxt = r_lane;
    w_push     = 1'b0;
    if (w_accept) begin
      unique case (r_lane)
        LANE0: w_lane_nxt = LANE1;
        LANE1: w_lane_nxt = LANE2;
        LANE2: w_lane_nxt = LANE3;
        LANE3: begin
          w_lane_nxt = LANE0;
          w_push     = 1'b1;
        end
        default: w_lane_nxt = LANE0;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n || bus.clr) begin
      r_lane  <= LANE0;
      r_asm   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_lane <= w_lane_nxt;
      if (w_accept) begin
        unique case (r_lane)
          LANE0:   r_asm[7:0]   <= bus.res_in;
          LANE1:   r_asm[15:8]  <= bus.res_in;
          LANE2:   r_asm[23:16] <= bus.res_in;
          default: r_asm        <= '0;
        endcase
      end
      if (w_wr)
        r_wptr <= r_wptr + 1'b1;
      if (w_pop)
        r_rptr <= r_rptr + 1'b1;
      r_level <= r_level + {{(LW-1){1'b0}}, w_wr} - {{(LW-1){1'b0}}, w_pop};
      if (w_drop)
        r_ovf <= 1'b1;
    end
  end

  // Word storage carries no reset; validity is tracked by the level counter.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_n && !bus.clr && w_wr)
      r_mem[r_wptr] <= w_word;
  end

  assign bus.rd_data  = r_mem[r_rptr];
  assign bus.rd_valid = (r_level != '0);
  assign bus.level    = r_level;
  assign bus.byte_idx = r_lane;
  assign bus.overflow = r_ovf;
endmodule

// File: tb/tb_cordic_result_packer.sv
// Scoreboard bench for cordic_result_packer: expected words are queued as bytes
// are driven and popped against rd_data when the bench reads the FIFO.
module tb_cordic_result_packer;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  cordic_result_packer_if #(.FIFO_DEPTH(DEPTH)) bus ();

  cordic_result_packer #(.FIFO_DEPTH(DEPTH)) dut (
    .wb_clk_i (clk),
    .wb_rst_n (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] sb_q[$];
  logic [1:0]  m_lane = 2'd0;
  logic [23:0] m_part = 24'd0;
  logic        m_ovf  = 1'b0;

  function automatic logic [6:0] exp_status();
    return {sb_q.size() != 0, 3'(sb_q.size()), m_lane, m_ovf};
  endfunction

  function automatic logic [6:0] act_status();
    return {bus.rd_valid, bus.level, bus.byte_idx, bus.overflow};
  endfunction

  // One clock: drive inputs, take the edge, advance the reference model.
  task automatic cyc(input logic cap, input logic val, input logic [7:0] b,
                     input logic rd, input logic cl, input logic rs);
    logic pop;
    bus.cap_en    = cap;
    bus.res_valid = val;
    bus.res_in    = b;
    bus.rd_en     = rd;
    bus.clr       = cl;
    rst_n         = ~rs;
    @(posedge clk);
    #1;
    if (rs || cl) begin
      m_lane = 2'd0;
      m_part = 24'd0;
      m_ovf  = 1'b0;
      sb_q.delete();
    end else begin
      pop = rd && (sb_q.size() > 0);
      if (pop)
        void'(sb_q.pop_front());
      if (cap && val) begin
        if (m_lane == 2'd3) begin
          if (sb_q.size() < DEPTH)
            sb_q.push_back({b, m_part});
          else
            m_ovf = 1'b1;
          m_lane = 2'd0;
          m_part = 24'd0;
        end else begin
          m_part[8*m_lane +: 8] = b;
          m_lane = m_lane + 2'd1;
        end
      end
    end
    bus.cap_en    = 1'b0;
    bus.res_valid = 1'b0;
    bus.rd_en     = 1'b0;
    bus.clr       = 1'b0;
    rst_n         = 1'b1;
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if (act_status() !== 7'b0_000_00_0)
      $display("FAIL reset_status: got %b want %b", act_status(), 7'b0_000_00_0);
    else
      n_pass++;
  endtask

  task automatic test_basic();
    do_reset();
    cyc(1, 1, 8'h11, 0, 0, 0);
    cyc(1, 1, 8'h22, 0, 0, 0);
    cyc(1, 1, 8'h33, 0, 0, 0);
    cyc(1, 1, 8'h44, 0, 0, 0);
    n_chk++;
    if (act_status() !== 7'b1_001_00_0)
      $display("FAIL basic_status: got %b want %b", act_status(), 7'b1_001_00_0);
    else
      n_pass++;
    n_chk++;
    if (bus.rd_data !== 32'h44332211)
      $display("FAIL basic_word: got %h want %h", bus.rd_data, 32'h44332211);
    else
      n_pass++;
    cyc(0, 0, 8'h00, 1, 0, 0);
    n_chk++;
    if (act_status() !== exp_status())
      $display("FAIL basic_after_pop: got %b want %b", act_status(), exp_status());
    else
      n_pass++;
  endtask

  task automatic test_gap();
    do_reset();
    cyc(1, 1, 8'hA0, 0, 0, 0);
    cyc(1, 1, 8'hA1, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      cyc(0, 1, 8'hF0 + 8'(i), 0, 0, 0);
    n_chk++;
    if (bus.byte_idx !== 2'd2 || bus.rd_valid !== 1'b0)
      $display("FAIL gap_hold: got idx=%0d vld=%b want idx=2 vld=0", bus.byte_idx, bus.rd_valid);
    else
      n_pass++;
    cyc(1, 1, 8'hA2, 0, 0, 0);
    cyc(1, 1, 8'hA3, 0, 0, 0);
    n_chk++;
    if (bus.rd_data !== 32'hA3A2A1A0 || sb_q.size() != 1 || bus.rd_data !== sb_q[0])
      $display("FAIL gap_word: got %h want %h", bus.rd_data, 32'hA3A2A1A0);
    else
      n_pass++;
  endtask

  task automatic test_overflow();
    logic [31:0] exp_w;
    do_reset();
    for (int w = 0; w < 5; w++)
      for (int k = 0; k < 4; k++)
        cyc(1, 1, 8'(16*w + k + 1), 0, 0, 0);
    n_chk++;
    if (act_status() !== 7'b1_100_00_1)
      $display("FAIL ovf_status: got %b want %b", act_status(), 7'b1_100_00_1);
    else
      n_pass++;
    for (int w = 0; w < 4; w++) begin
      exp_w = {8'(16*w + 4), 8'(16*w + 3), 8'(16*w + 2), 8'(16*w + 1)};
      n_chk++;
      if (bus.rd_data !== exp_w || sb_q.size() == 0 || bus.rd_data !== sb_q[0])
        $display("FAIL ovf_pop%0d: got %h want %h", w, bus.rd_data, exp_w);
      else
        n_pass++;
      cyc(0, 0, 8'h00, 1, 0, 0);
    end
    n_chk++;
    if (act_status() !== 7'b0_000_00_1)
      $display("FAIL ovf_drained: got %b want %b", act_status(), 7'b0_000_00_1);
    else
      n_pass++;
    cyc(0, 0, 8'h00, 0, 1, 0);
    n_chk++;
    if (bus.overflow !== 1'b0)
      $display("FAIL ovf_clr: got %b want 0", bus.overflow);
    else
      n_pass++;
  endtask

  task automatic test_full_pushpop();
    logic [31:0] got;
    do_reset();
    for (int w = 0; w < 4; w++)
      for (int k = 0; k < 4; k++)
        cyc(1, 1, 8'(16*w + k), 0, 0, 0);
    cyc(1, 1, 8'hC0, 0, 0, 0);
    cyc(1, 1, 8'hC1, 0, 0, 0);
    cyc(1, 1, 8'hC2, 0, 0, 0);
    n_chk++;
    if (bus.rd_data !== sb_q[0])
      $display("FAIL full_head: got %h want %h", bus.rd_data, sb_q[0]);
    else
      n_pass++;
    cyc(1, 1, 8'hC3, 1, 0, 0);
    n_chk++;
    if (act_status() !== 7'b1_100_00_0)
      $display("FAIL full_pushpop: got %b want %b", act_status(), 7'b1_100_00_0);
    else
      n_pass++;
    for (int w = 0; w < 4; w++) begin
      got = bus.rd_data;
      n_chk++;
      if (got !== sb_q[0])
        $display("FAIL full_drain%0d: got %h want %h", w, got, sb_q[0]);
      else
        n_pass++;
      cyc(0, 0, 8'h00, 1, 0, 0);
    end
    n_chk++;
    if (got !== 32'hC3C2C1C0 || bus.rd_valid !== 1'b0)
      $display("FAIL full_last: got %h vld=%b want c3c2c1c0 vld=0", got, bus.rd_valid);
    else
      n_pass++;
  endtask

  task automatic test_clear(input logic use_rst);
    do_reset();
    for (int k = 0; k < 4; k++)
      cyc(1, 1, 8'h50 + 8'(k), 0, 0, 0);
    cyc(1, 1, 8'h60, 0, 0, 0);
    cyc(1, 1, 8'h61, 0, 0, 0);
    cyc(1, 1, 8'h77, 0, ~use_rst, use_rst);
    n_chk++;
    if (act_status() !== 7'b0_000_00_0)
      $display("FAIL clear_status(rst=%0b): got %b want %b", use_rst, act_status(), 7'b0_000_00_0);
    else
      n_pass++;
    cyc(1, 1, 8'h01, 0, 0, 0);
    cyc(1, 1, 8'h02, 0, 0, 0);
    cyc(1, 1, 8'h03, 0, 0, 0);
    cyc(1, 1, 8'h04, 0, 0, 0);
    n_chk++;
    if (bus.rd_data !== 32'h04030201 || bus.level !== 3'd1)
      $display("FAIL clear_next(rst=%0b): got %h lvl=%0d want 04030201 lvl=1", use_rst, bus.rd_data, bus.level);
    else
      n_pass++;
  endtask

  task automatic test_pop_empty();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 8'h00, 1, 0, 0);
      n_chk++;
      if (act_status() !== 7'b0_000_00_0)
        $display("FAIL pop_empty%0d: got %b want %b", i, act_status(), 7'b0_000_00_0);
      else
        n_pass++;
    end
  endtask

  task automatic test_random();
    logic cap, val, rd, cl, rs;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cap = ($urandom_range(0, 3) != 0);
      val = ($urandom_range(0, 3) != 0);
      rd  = ($urandom_range(0, 2) == 0);
      cl  = ($urandom_range(0, 59) == 0);
      rs  = ($urandom_range(0, 99) == 0);
      if (rd && sb_q.size() > 0) begin
        n_chk++;
        if (bus.rd_data !== sb_q[0])
          $display("FAIL rand_word@%0d: got %h want %h", i, bus.rd_data, sb_q[0]);
        else
          n_pass++;
      end
      cyc(cap, val, 8'($urandom), rd, cl, rs);
      n_chk++;
      if (act_status() !== exp_status())
        $display("FAIL rand_status@%0d: got %b want %b", i, act_status(), exp_status());
      else
        n_pass++;
    end
  endtask

  initial begin
    bus.cap_en    = 1'b0;
    bus.res_valid = 1'b0;
    bus.res_in    = 8'h00;
    bus.clr       = 1'b0;
    bus.rd_en     = 1'b0;
    test_reset();
    test_basic();
    test_gap();
    test_overflow();
    test_full_pushpop();
    test_clear(1'b0);
    test_clear(1'b1);
    test_pop_empty();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cordic_result_packer.md
CORDIC_RESULT_PACKER -- requirements
Module: cordic_result_packer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, number of 32-bit words buffered; power of two, at least 2.
REQ-002 wb_clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 wb_rst_n  input  1  reset, synchronous, active-low.
REQ-004 cap_en  input  1  capture enable; bytes are accepted only while high.
REQ-005 res_valid  input  1  strobe; res_in holds a valid CORDIC result byte this cycle.
REQ-006 res_in  input  8  result byte from the CORDIC stage output bus.
REQ-007 clr  input  1  synchronous soft clear of packer, FIFO and flags.
REQ-008 rd_en  input  1  pop request for the FIFO head word.
REQ-009 rd_data  output  32  FIFO head word (first-word-fall-through).
REQ-010 rd_valid  output  1  FIFO not empty; rd_data is meaningful.
REQ-011 level  output  $clog2(FIFO_DEPTH)+1  number of words currently stored.
REQ-012 byte_idx  output  2  lane the next accepted byte will fill.
REQ-013 overflow  output  1  sticky; a completed word was dropped because the FIFO was full.

Function
REQ-014 A byte is accepted on an edge where cap_en=1 and res_valid=1; there is no other accept condition.
REQ-015 The packer state is byte_idx with values LANE0->LANE1->LANE2->LANE3->LANE0; it advances by one per accepted byte only.
REQ-016 An accepted byte is written to bits [8*byte_idx+7 : 8*byte_idx] of the assembly register, so byte order is little-endian.
REQ-017 The byte accepted in LANE3 completes a word; on that same edge the completed word (lanes 0-2 from the register, lane 3 from res_in) is pushed to the FIFO tail.
REQ-018 Latency: the fourth byte is accepted at edge N -> rd_valid=1 and rd_data=word in the cycle after edge N when the FIFO was empty.
REQ-019 Deasserting cap_en mid-word holds byte_idx and the partial lanes unchanged indefinitely; capture resumes at the held lane.
REQ-020 rd_en with rd_valid=1 pops the head at the edge; rd_en with rd_valid=0 is ignored, with no state change and no flag.
REQ-021 Push and pop on the same edge: level is unchanged, and both take effect, including when the FIFO is full.
REQ-022 Push with FIFO full and no simultaneous pop: the word is discarded, overflow is set to 1, byte_idx still wraps to LANE0, and the FIFO contents are unchanged.
REQ-023 overflow stays 1 until clr or reset.
REQ-024 Read and write pointers wrap modulo FIFO_DEPTH; level counts 0..FIFO_DEPTH inclusive, so full and empty are distinguished by level.
REQ-025 clr=1 takes priority over accept, push and pop on the same edge.
REQ-026 clr=1 sets byte_idx=0, level=0, overflow=0, and clears the assembly register to 0.
REQ-027 A byte presented on the clr edge is discarded.
REQ-028 FIFO storage is not required to be cleared by clr or reset; rd_data is don't-care while rd_valid=0.
REQ-029 Input-to-output paths contain no combinational loops; rd_data, rd_valid and level depend on registered state only.

Reset
REQ-030 wb_rst_n=0 sampled at an edge takes priority over clr and over all inputs.
REQ-031 The reset edge forces byte_idx=0, level=0, rd_valid=0, overflow=0, assembly register=0 and both pointers=0.
REQ-032 Reset asserted mid-word or with a non-empty FIFO discards all partial and stored data; the first byte accepted after release fills LANE0.
REQ-033 Outputs after reset, until the first accepted byte: rd_valid=0, level=0, byte_idx=0, overflow=0.

Verification
REQ-034 Basic packing: after reset, accept bytes 0x11,0x22,0x33,0x44 on consecutive cycles -> the next cycle shows rd_valid=1, rd_data=0x44332211, level=1, byte_idx=0.
REQ-035 Gaps in capture: bytes 0xA0,0xA1 accepted, then cap_en=0 for 5 cycles with res_valid=1, then 0xA2,0xA3 accepted -> rd_data=0xA3A2A1A0, and no byte is captured during the gap.
REQ-036 Overflow: with FIFO_DEPTH=4, push 5 words without reads -> level=4, overflow=1; pop 4 times -> words 1-4 in order, then rd_valid=0.
REQ-037 Simultaneous push/pop when full: FIFO full, the fourth byte of a word arrives with rd_en=1 -> level stays 4, overflow stays 0, and the new word is read out last.
REQ-038 Clear and reset mid-operation:
- 2 bytes accepted, 1 word stored, then clr=1 together with res_valid=1 -> level=0, byte_idx=0, and that byte is dropped.
- Repeating the sequence with wb_rst_n=0 instead of clr gives an identical result.
REQ-039 Pop on empty: after reset, pulse rd_en=1 for 3 cycles -> level stays 0, rd_valid=0, overflow=0.
